// File: rtl/fc_acc_bank.sv
// rtl/fc_acc_bank.sv - bias-preloaded, flow-controlled FC accumulator bank
// Optional argmax stage enabled by defining FC_ACC_ARGMAX_EN.
module fc_acc_bank #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH     = 10,
  parameter int NUM_TERMS  = 16,
  parameter int ARITH_TYPE = 0,
  parameter int CNT_W      = $clog2(NUM_TERMS + 1),
  parameter int IDX_W      = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [IDX_W-1:0]             class_idx
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC    = 2'd1,
    DONE   = 2'd2
`ifdef FC_ACC_ARGMAX_EN
    , ARGMAX = 2'd3
`endif
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] acc     [NUM_CH];
  logic [DATA_WIDTH-1:0] acc_sum [NUM_CH];
  logic [CNT_W-1:0]      term_cnt;
  logic                  do_load;
  logic                  last_term;

  // Saturation clamps only when both operands share a sign the sum lost.
  function automatic logic [DATA_WIDTH-1:0] add_fn(input logic [DATA_WIDTH-1:0] a,
                                                   input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-1:0] s;
    s = a + b;
    if (ARITH_TYPE == 1 && a[DATA_WIDTH-1] == b[DATA_WIDTH-1] && s[DATA_WIDTH-1] != a[DATA_WIDTH-1])
      s = a[DATA_WIDTH-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return s;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign acc_sum[g] = add_fn(acc[g], data_in[g*DATA_WIDTH +: DATA_WIDTH]);
    assign data_out[g*DATA_WIDTH +: DATA_WIDTH] = acc[g];
  end

  // start restarts from any state except DONE, where it needs the handshake too.
  assign do_load   = start && (state != DONE || out_ready);
  assign last_term = (term_cnt == CNT_W'(NUM_TERMS - 1));

`ifdef FC_ACC_ARGMAX_EN
  logic [DATA_WIDTH-1:0] best;
  logic [IDX_W-1:0]      arg_idx;
  logic [IDX_W-1:0]      class_idx_r;
  assign class_idx = class_idx_r;
`else
  assign class_idx = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      term_cnt  <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) acc[i] <= '0;
`ifdef FC_ACC_ARGMAX_EN
      best        <= '0;
      arg_idx     <= '0;
      class_idx_r <= '0;
`endif
    end else if (do_load) begin
      for (int i = 0; i < NUM_CH; i++) acc[i] <= data_bias[i*DATA_WIDTH +: DATA_WIDTH];
      term_cnt  <= '0;
      state     <= ACC;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b1;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            for (int i = 0; i < NUM_CH; i++) acc[i] <= acc_sum[i];
            term_cnt <= term_cnt + CNT_W'(1);
            if (last_term) begin
              in_ready <= 1'b0;
`ifdef FC_ACC_ARGMAX_EN
              // Seed the search with channel 0's final value, not the stale register.
              state       <= ARGMAX;
              best        <= acc_sum[0];
              class_idx_r <= '0;
              arg_idx     <= IDX_W'(1);
`else
              state     <= DONE;
              out_valid <= 1'b1;
`endif
            end
          end
        end
`ifdef FC_ACC_ARGMAX_EN
        ARGMAX: begin
          if ($signed(acc[arg_idx]) > $signed(best)) begin
            best        <= acc[arg_idx];
            class_idx_r <= arg_idx;
          end
          if (arg_idx == IDX_W'(NUM_CH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            arg_idx <= arg_idx + IDX_W'(1);
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_acc_bank.sv
// tb/tb_fc_acc_bank.sv - table-driven scoreboard bench for fc_acc_bank (wrap and saturating builds)
// Honours FC_ACC_ARGMAX_EN for latency and class_idx expectations.
module tb_fc_acc_bank;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int NT = 3;
  localparam int IW = 2;
  localparam int NV = 5;
`ifdef FC_ACC_ARGMAX_EN
  localparam int  EXP_LAT = NC - 1;
  localparam bit  ARGMAX  = 1'b1;
`else
  localparam int  EXP_LAT = 0;
  localparam bit  ARGMAX  = 1'b0;
`endif

  typedef struct packed {
    logic [NC*DW-1:0]    bias;
    logic [NT*NC*DW-1:0] terms;
    logic [NC*DW-1:0]    exp_w;
    logic [NC*DW-1:0]    exp_s;
    logic [IW-1:0]       idx_w;
    logic [IW-1:0]       idx_s;
  } tv_t;

  logic             clk = 1'b0;
  logic             reset, start, in_valid, out_ready;
  logic [NC*DW-1:0] data_bias, data_in;
  logic [NC*DW-1:0] data_out_w, data_out_s;
  logic             in_ready_w, in_ready_s, out_valid_w, out_valid_s, busy_w, busy_s;
  logic [IW-1:0]    class_idx_w, class_idx_s;

  int  n_tests = 0;
  int  n_fail  = 0;
  tv_t tv [NV];
  tv_t sb [$];

  always #5 clk = ~clk;

  fc_acc_bank #(.DATA_WIDTH(DW), .NUM_CH(NC), .NUM_TERMS(NT), .ARITH_TYPE(0)) dut_w (
    .clk(clk), .reset(reset), .start(start), .data_bias(data_bias),
    .in_valid(in_valid), .in_ready(in_ready_w), .data_in(data_in),
    .data_out(data_out_w), .out_valid(out_valid_w), .out_ready(out_ready),
    .busy(busy_w), .class_idx(class_idx_w));

  fc_acc_bank #(.DATA_WIDTH(DW), .NUM_CH(NC), .NUM_TERMS(NT), .ARITH_TYPE(1)) dut_s (
    .clk(clk), .reset(reset), .start(start), .data_bias(data_bias),
    .in_valid(in_valid), .in_ready(in_ready_s), .data_in(data_in),
    .data_out(data_out_s), .out_valid(out_valid_s), .out_ready(out_ready),
    .busy(busy_s), .class_idx(class_idx_s));

  function automatic logic [NC*DW-1:0] p4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [NC*DW-1:0] bias);
    data_bias = bias;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Terms are separated by idle cycles carrying garbage data that must be ignored.
  task automatic feed(input tv_t t);
    for (int k = 0; k < NT; k++) begin
      check("in_ready_w", 64'(in_ready_w), 64'd1);
      check("in_ready_s", 64'(in_ready_s), 64'd1);
      check("no_early_valid", 64'(out_valid_w | out_valid_s), 64'd0);
      data_in  = t.terms[k*NC*DW +: NC*DW];
      in_valid = 1'b1;
      if (k == NT - 1) sb.push_back(t);
      tick();
      in_valid = 1'b0;
      data_in  = {$urandom, $urandom};
      if (k < NT - 1) tick();
    end
  endtask

  task automatic collect(input int hold, input bit release_it);
    tv_t e;
    int  lat = 0;
    while (!(out_valid_w && out_valid_s) && lat < 30) begin
      tick();
      lat++;
    end
    check("latency", 64'(lat), 64'(EXP_LAT));
    check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("data_out_wrap", data_out_w, e.exp_w);
      check("data_out_sat", data_out_s, e.exp_s);
      check("class_idx_wrap", 64'(class_idx_w), ARGMAX ? 64'(e.idx_w) : 64'd0);
      check("class_idx_sat", 64'(class_idx_s), ARGMAX ? 64'(e.idx_s) : 64'd0);
      check("ready_valid_excl", 64'(in_ready_w | in_ready_s), 64'd0);
      // out_valid must hold, including across a start that lacks out_ready.
      for (int h = 0; h < hold; h++) begin
        start = (h == 1);
        tick();
        start = 1'b0;
        check("hold_valid", 64'(out_valid_w & out_valid_s), 64'd1);
        check("hold_data", data_out_w, e.exp_w);
      end
    end
    if (release_it) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("release_valid", 64'(out_valid_w | out_valid_s), 64'd0);
      check("release_busy", 64'(busy_w | busy_s), 64'd0);
    end
  endtask

  initial begin
    tv_t t;
    tv[0] = '{p4(1,2,3,4), {3{p4(10,10,10,10)}}, p4(31,32,33,34), p4(31,32,33,34), 2'd3, 2'd3};
    tv[1] = '{p4(32760,-32760,0,0), {p4(0,0,0,0), p4(0,0,0,0), p4(10,-10,0,0)},
              p4(-32766,32766,0,0), p4(32767,-32768,0,0), 2'd1, 2'd0};
    tv[2] = '{p4(0,0,0,0), {p4(2,-1,3,3), p4(2,-1,3,3), p4(1,-1,3,3)},
              p4(5,-3,9,9), p4(5,-3,9,9), 2'd2, 2'd2};
    tv[3] = '{p4(7,7,7,7), {3{p4(1,1,1,1)}}, p4(10,10,10,10), p4(10,10,10,10), 2'd0, 2'd0};
    tv[4] = '{p4(-32768,32767,100,-100), {3{p4(-1,1,-200,200)}},
              p4(32765,-32766,-500,500), p4(-32768,32767,-500,500), 2'd0, 2'd1};

    reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_bias = '0; data_in = '0;
    tick(); tick();
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      start     = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      data_bias = {$urandom, $urandom};
      data_in   = {$urandom, $urandom};
      tick();
    end
    reset = 1'b0;
    tick(); tick();
    check("rst_data_w", data_out_w, 64'd0);
    check("rst_data_s", data_out_s, 64'd0);
    check("rst_valid", 64'(out_valid_w | out_valid_s), 64'd0);
    check("rst_ready", 64'(in_ready_w | in_ready_s), 64'd0);
    check("rst_busy", 64'(busy_w | busy_s), 64'd0);
    check("rst_class", 64'({class_idx_w, class_idx_s}), 64'd0);
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();

    for (int v = 0; v < NV; v++) begin
      do_start(tv[v].bias);
      check("bias_load", data_out_w, tv[v].bias);
      check("busy_acc", 64'(busy_w & busy_s), 64'd1);
      feed(tv[v]);
      collect((v == 0) ? 5 : 1, 1'b1);
    end

    // Restart after one term, with a concurrent term that must be dropped.
    do_start(p4(0,0,0,0));
    data_in = p4(100,100,100,100); in_valid = 1'b1;
    tick();
    data_in = p4(1000,1000,1000,1000); start = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0;
    check("restart_clear", data_out_w, 64'd0);
    t = '{p4(0,0,0,0), {3{p4(10,10,10,10)}}, p4(30,30,30,30), p4(30,30,30,30), 2'd0, 2'd0};
    feed(t);
    collect(1, 1'b1);

    // Reset in the middle of ACC, then a normal run.
    do_start(tv[0].bias);
    data_in = p4(10,10,10,10); in_valid = 1'b1;
    tick();
    in_valid = 1'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_data", data_out_w | data_out_s, 64'd0);
    check("midrst_busy", 64'(busy_w | busy_s), 64'd0);
    check("midrst_ready", 64'(in_ready_w | in_ready_s), 64'd0);
    do_start(tv[0].bias);
    feed(tv[0]);
    collect(0, 1'b0);

    // Back-to-back: start with out_ready straight from DONE into ACC.
    data_bias = p4(100,200,300,400); start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; out_ready = 1'b0;
    check("b2b_valid", 64'(out_valid_w | out_valid_s), 64'd0);
    check("b2b_ready", 64'(in_ready_w & in_ready_s), 64'd1);
    check("b2b_bias", data_out_s, p4(100,200,300,400));
    t = '{p4(100,200,300,400), {3{p4(1,2,3,4)}}, p4(103,206,309,412), p4(103,206,309,412), 2'd3, 2'd3};
    feed(t);
    collect(2, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fc_acc_bank.md
Name: fc_acc_bank

Overview:
- Parametrised NUM_CH-channel accumulator bank for the fully-connected layer output stage.
- Each channel is preloaded with its bias, then accumulates NUM_TERMS partial sums from the FC MAC array under a valid/ready handshake.
- Presents the final results with a held out_valid until the consumer (softmax/argmax stage or host readout) acknowledges.
- Replaces fixed-count, free-running register accumulators with a counted, flow-controlled, restartable block.

Parameters:
- DATA_WIDTH, 32: width of each channel's data, bias and accumulator.
- NUM_CH, 10: number of output channels; minimum 2.
- NUM_TERMS, 16: accumulation terms per inference; minimum 1.
- ARITH_TYPE, 0: 0 = two's-complement add with wrap-around; 1 = signed saturating add.
- CNT_W, $clog2(NUM_TERMS+1): width of the term counter.
- IDX_W, $clog2(NUM_CH): width of class_idx.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse; load biases and begin an accumulation.
- data_bias  input  NUM_CH*DATA_WIDTH  packed biases; channel i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- in_valid  input  1  data_in carries a valid term.
- in_ready  output  1  block accepts terms (state ACC).
- data_in  input  NUM_CH*DATA_WIDTH  packed partial sums, same packing as data_bias.
- data_out  output  NUM_CH*DATA_WIDTH  packed accumulator registers, always visible.
- out_valid  output  1  results final; held until acknowledged.
- out_ready  input  1  consumer acknowledge.
- busy  output  1  high when not IDLE.
- class_idx  output  IDX_W  argmax result (see Optional Feature).

Behaviour:
- Reset: while reset==0 at a clock edge, all accumulators, term_cnt, class_idx, in_ready, out_valid and busy become 0; state becomes IDLE. Reset has priority over all other inputs, in every state.
- IDLE: start=1 → acc[i] <= bias[i], term_cnt <= 0, next state ACC. in_valid is ignored.
- ACC: in_ready=1.
  - in_valid=1 → acc[i] <= acc[i] + data_in[i] for every channel; term_cnt increments.
  - Accepting the term with term_cnt==NUM_TERMS-1 → next state DONE (or ARGMAX when enabled).
  - in_valid=0 → accumulators hold; gaps are unlimited.
  - start=1 in ACC aborts and restarts: biases reload, term_cnt <= 0, and any concurrent in_valid term is dropped.
- DONE: out_valid=1; data_out is stable.
  - out_ready=1 → next state IDLE, and out_valid is low in the following cycle.
  - start=1 together with out_ready=1 → handshake completes and the bank reloads biases straight into ACC.
  - start=1 without out_ready is ignored.
- Latency: out_valid rises in the cycle after the edge that accepts the final term (argmax disabled).
- Arithmetic, ARITH_TYPE=0: result is (a+b) mod 2^DATA_WIDTH.
- Arithmetic, ARITH_TYPE=1: on signed overflow the result clamps to 2^(DATA_WIDTH-1)-1 (positive) or -2^(DATA_WIDTH-1) (negative). Saturation is applied on every add.
- Bias load is a plain copy, with no arithmetic.
- in_ready and out_valid are never high simultaneously.

Optional Feature:
- Macro: FC_ACC_ARGMAX_EN.
- Defined:
  - After the final term the FSM enters ARGMAX. On entry, best <= acc[0] and class_idx <= 0.
  - Each of the next NUM_CH-1 cycles compares one channel (1..NUM_CH-1, ascending) as a signed value. A strictly greater value updates best and class_idx, so ties keep the lower index.
  - Then the FSM enters DONE; out_valid rises NUM_CH-1 cycles later than without the feature.
  - class_idx is valid while out_valid=1.
  - start during ARGMAX restarts exactly as in ACC.
- Undefined: no ARGMAX state; class_idx is tied to 0.

Test Plan:
- Reset: reset=0 for 2 cycles after random activity → data_out all 0; out_valid, in_ready and busy all 0.
- Basic accumulation (NUM_CH=4, DATA_WIDTH=16, NUM_TERMS=3):
  - Stimulus: bias {1,2,3,4}, start, then three terms {10,10,10,10} with in_valid low between terms.
  - Expected: data_out {31,32,33,34}; out_valid high the cycle after the 3rd term and held for 5 cycles with out_ready=0; IDLE after out_ready.
- Arithmetic:
  - ARITH_TYPE=1: bias {32760,-32760}, terms {10,-10} → {32767,-32768}.
  - ARITH_TYPE=0, same stimulus → {-32766,32766}.
- Restart: start after 1 accepted term, bias {0,0,0,0} → the earlier term is discarded; out_valid only after 3 further terms; result equals the sum of those 3 terms.
- Reset mid-operation and back-to-back:
  - reset=0 during ACC → IDLE, data_out 0 next cycle, and a subsequent start works normally.
  - start with out_ready in DONE → ACC directly with biases loaded.
- FC_ACC_ARGMAX_EN:
  - Final data_out {5,-3,9,9} → class_idx=2; out_valid arrives 3 cycles later than in the non-argmax build.
  - All channels equal → class_idx=0.
